fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/iitb_risc_pkg.sv | 37 +++
 rtl/next_pc_sel.sv | 30 +++
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iitb_risc_pkg.sv
// Shared definitions for the IITB-RISC core: word width, opcode map and
// the instruction-fetch FSM state type.
package iitb_risc_pkg;

    localparam int WORD_W = 16;
    typedef logic [WORD_W-1:0] word_t;

    localparam logic [3:0] OPC_ADI  = 4'b0000;
    localparam logic [3:0] OPC_ADD  = 4'b0001;
    localparam logic [3:0] OPC_NAND = 4'b0010;
    localparam logic [3:0] OPC_LLI  = 4'b0011;
    localparam logic [3:0] OPC_LW   = 4'b0100;
    localparam logic [3:0] OPC_SW   = 4'b0101;
    localparam logic [3:0] OPC_LM   = 4'b0110;
    // Unused encoding: the controller treats it as a bubble with no side effects.
    localparam logic [3:0] OPC_NOP  = 4'b0111;
    localparam logic [3:0] OPC_BEQ  = 4'b1000;
    localparam logic [3:0] OPC_BLT  = 4'b1001;
    localparam logic [3:0] OPC_BLE  = 4'b1010;
    localparam logic [3:0] OPC_JAL  = 4'b1100;
    localparam logic [3:0] OPC_JLR  = 4'b1101;
    localparam logic [3:0] OPC_JRI  = 4'b1111;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_ISSUE = 1'b1
    } fetch_state_e;

    function automatic word_t sext9(input logic [8:0] imm);
        return {{(WORD_W-9){imm[8]}}, imm};
    endfunction

    function automatic word_t sext6(input logic [5:0] imm);
        return {{(WORD_W-6){imm[5]}}, imm};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC target selection; all arithmetic wraps modulo 2^16.
module next_pc_sel
    import iitb_risc_pkg::*;
(
    input  logic [15:0] pc,
    input  logic [8:0]  imm9,
    input  logic [15:0] rf_ra_data,
    input  logic [15:0] rf_rb_data,
    input  logic        jump_jlr,
    input  logic        jump_jri,
    input  logic        jump_jal,
    input  logic        branch_taken,
    output logic [15:0] next_pc
);

    always_comb begin
        next_pc = pc + 16'd1;
        if (jump_jlr) begin
            next_pc = rf_rb_data;
        end else if (jump_jri) begin
            next_pc = rf_ra_data + sext9(imm9);
        end else if (jump_jal) begin
            next_pc = pc + sext9(imm9);
        end else if (branch_taken) begin
            // BEQ offset lives in the low six bits of the same immediate field.
            next_pc = pc + sext6(imm9[5:0]);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches one word, holds it until the execute stage
// acknowledges it, then advances the PC.
module fetch_unit
    import iitb_risc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_en,
    input  logic        branch_beq,
    input  logic        jump_jal,
    input  logic        jump_jlr,
    input  logic        jump_jri,
    input  logic        beq_equal,
    input  logic [15:0] rf_ra_data,
    input  logic [15:0] rf_rb_data,
    input  logic        instr_ack,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [3:0]  opcode,
    output logic [15:0] pc,
    output logic [15:0] pc_plus1,
    output logic [15:0] retired_count
);

    fetch_state_e state_q;
    logic [15:0]  pc_q;
    logic [15:0]  pc_d;
    logic [15:0]  instr_q;
    logic [15:0]  retired_q;

    next_pc_sel u_next_pc_sel (
        .pc           (pc_q),
        .imm9         (instr_q[8:0]),
        .rf_ra_data   (rf_ra_data),
        .rf_rb_data   (rf_rb_data),
        .jump_jlr     (jump_jlr),
        .jump_jri     (jump_jri),
        .jump_jal     (jump_jal),
        .branch_taken (branch_beq & beq_equal),
        .next_pc      (pc_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= 16'h0000;
            retired_q <= 16'h0000;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (instr_ack) begin
                        state_q   <= S_FETCH;
                        retired_q <= retired_q + 16'd1;
                        // pc_en=0 keeps the PC, so the same word is fetched again.
                        if (pc_en) begin
                            pc_q <= pc_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    // State resets to S_FETCH, so the request is also gated by rst_n to keep
    // the memory port quiet while reset is held.
    assign imem_req      = rst_n & (state_q == S_FETCH);
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign instr_valid   = (state_q == S_ISSUE);
    assign opcode        = instr_valid ? instr_q[15:12] : OPC_NOP;
    assign pc            = pc_q;
    assign pc_plus1      = pc_q + 16'd1;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an expected-fetch-address scoreboard.
module tb_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_en, branch_beq, jump_jal, jump_jlr, jump_jri, beq_equal;
    logic [15:0] rf_ra_data, rf_rb_data;
    logic        instr_ack;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [15:0] pc, pc_plus1, retired_count;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] sb_addr[$];
    logic [15:0] m_pc;
    logic [15:0] m_ret;
    logic [15:0] m_instr;
    logic [15:0] held_addr;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_en         (pc_en),
        .branch_beq    (branch_beq),
        .jump_jal      (jump_jal),
        .jump_jlr      (jump_jlr),
        .jump_jri      (jump_jri),
        .beq_equal     (beq_equal),
        .rf_ra_data    (rf_ra_data),
        .rf_rb_data    (rf_rb_data),
        .instr_ack     (instr_ack),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .opcode        (opcode),
        .pc            (pc),
        .pc_plus1      (pc_plus1),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_next(input logic [15:0] cur, input logic [15:0] w,
                                               input logic jlr, input logic jri, input logic jal,
                                               input logic beq, input logic eq,
                                               input logic [15:0] ra, input logic [15:0] rb);
        logic [15:0] i9;
        logic [15:0] i6;
        i9 = {{7{w[8]}}, w[8:0]};
        i6 = {{10{w[5]}}, w[5:0]};
        if (jlr)             return rb;
        else if (jri)        return ra + i9;
        else if (jal)        return cur + i9;
        else if (beq && eq)  return cur + i6;
        else                 return cur + 16'd1;
    endfunction

    function automatic logic [15:0] pop_addr();
        logic [15:0] a;
        if (sb_addr.size() == 0) begin
            a = 16'hxxxx;
        end else begin
            a = sb_addr.pop_front();
        end
        return a;
    endfunction

    // Fetch one word after `waits` not-ready cycles; instr_ack is held high
    // while waiting to show it is ignored in the fetch state.
    task automatic do_fetch(input logic [15:0] word, input int waits);
        logic [15:0] exp_addr;
        exp_addr = pop_addr();
        check("fetch_req", {15'b0, imem_req}, 16'h0001);
        check("fetch_addr", imem_addr, exp_addr);
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            instr_ack  = 1'b1;
            step();
            check("wait_req", {15'b0, imem_req}, 16'h0001);
            check("wait_addr", imem_addr, exp_addr);
            check("wait_valid", {15'b0, instr_valid}, 16'h0000);
            check("wait_retired", retired_count, m_ret);
        end
        instr_ack  = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        imem_ready = 1'b0;
        imem_rdata = 16'hDEAD;
        m_instr    = word;
        $display("fetch addr=%h word=%h waits=%0d", exp_addr, word, waits);
        check("issue_valid", {15'b0, instr_valid}, 16'h0001);
        check("issue_instr", instr, word);
        check("issue_opcode", {12'b0, opcode}, {12'b0, word[15:12]});
        check("issue_req", {15'b0, imem_req}, 16'h0000);
    endtask

    task automatic do_issue(input logic en, input logic jlr, input logic jri, input logic jal,
                            input logic beq, input logic eq,
                            input logic [15:0] ra, input logic [15:0] rb);
        logic [15:0] nxt;
        pc_en = en; jump_jlr = jlr; jump_jri = jri; jump_jal = jal;
        branch_beq = beq; beq_equal = eq; rf_ra_data = ra; rf_rb_data = rb;
        instr_ack = 1'b1;
        nxt = model_next(m_pc, m_instr, jlr, jri, jal, beq, eq, ra, rb);
        step();
        instr_ack = 1'b0;
        pc_en = 1'b0; jump_jlr = 1'b0; jump_jri = 1'b0; jump_jal = 1'b0;
        branch_beq = 1'b0; beq_equal = 1'b0;
        m_ret = m_ret + 16'd1;
        if (en) m_pc = nxt;
        sb_addr.push_back(m_pc);
        $display("ack pc_en=%b jlr=%b jri=%b jal=%b beq=%b eq=%b -> pc=%h retired=%h",
                 en, jlr, jri, jal, beq, eq, pc, retired_count);
        check("ack_pc", pc, m_pc);
        check("ack_pc_plus1", pc_plus1, m_pc + 16'd1);
        check("ack_retired", retired_count, m_ret);
        check("ack_valid", {15'b0, instr_valid}, 16'h0000);
    endtask

    task automatic model_reset();
        sb_addr.delete();
        sb_addr.push_back(RST_PC);
        m_pc  = RST_PC;
        m_ret = 16'h0000;
    endtask

    task automatic jump_to(input logic [15:0] target);
        do_fetch(16'hD000, 0);
        do_issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, target);
    endtask

    initial begin
        rst_n = 1'b0;
        pc_en = 1'b0; branch_beq = 1'b0; jump_jal = 1'b0; jump_jlr = 1'b0; jump_jri = 1'b0;
        beq_equal = 1'b0; rf_ra_data = 16'h0000; rf_rb_data = 16'h0000;
        instr_ack = 1'b0; imem_ready = 1'b0; imem_rdata = 16'h0000;
        model_reset();

        // Reset state
        step();
        step();
        check("rst_req", {15'b0, imem_req}, 16'h0000);
        check("rst_opcode", {12'b0, opcode}, 16'h0007);
        check("rst_valid", {15'b0, instr_valid}, 16'h0000);
        check("rst_pc", pc, RST_PC);
        check("rst_retired", retired_count, 16'h0000);
        check("rst_instr", instr, 16'h0000);
        rst_n = 1'b1;
        #1;
        check("rel_req", {15'b0, imem_req}, 16'h0001);
        check("rel_addr", imem_addr, RST_PC);

        // ADD at address 0, zero-wait, immediate ack
        do_fetch(16'h1050, 0);
        do_issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // BEQ taken and not taken from 0x0010
        jump_to(16'h0010);
        do_fetch(16'h803E, 0);
        // imem_ready in the issue state must not disturb the held word
        imem_ready = 1'b1;
        imem_rdata = 16'h5555;
        step();
        imem_ready = 1'b0;
        check("hold_instr", instr, 16'h803E);
        check("hold_valid", {15'b0, instr_valid}, 16'h0001);
        do_issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
        check("beq_taken_pc", pc, 16'h000E);
        jump_to(16'h0010);
        do_fetch(16'h803E, 0);
        do_issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        check("beq_not_taken_pc", pc, 16'h0011);

        // Wrap at 0xFFFF, then JAL backwards across zero
        jump_to(16'hFFFF);
        do_fetch(16'h1050, 0);
        do_issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("wrap_pc", pc, 16'h0000);
        check("wrap_pc_plus1", pc_plus1, 16'h0001);
        do_fetch(16'hC1FF, 0);
        do_issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("jal_neg_pc", pc, 16'hFFFF);

        // JLR beats JAL; JRI register-relative
        do_fetch(16'hD000, 0);
        do_issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234);
        check("jlr_prio_pc", pc, 16'h1234);
        do_fetch(16'hF010, 0);
        do_issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000);
        check("jri_pc", pc, 16'h0110);

        // pc_en=0: same address refetched, count still advances
        do_fetch(16'h1050, 0);
        do_issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("hold_pc", pc, 16'h0110);

        // Five not-ready cycles, then a normal completion
        do_fetch(16'h2000, 5);
        do_issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Reset in the third cycle of a stalled fetch
        held_addr = pop_addr();
        check("stall_addr", imem_addr, held_addr);
        step();
        step();
        check("stall_req", {15'b0, imem_req}, 16'h0001);
        rst_n = 1'b0;
        #1;
        $display("reset pulse during fetch at addr=%h", held_addr);
        check("midrst_req", {15'b0, imem_req}, 16'h0000);
        check("midrst_pc", pc, RST_PC);
        check("midrst_retired", retired_count, 16'h0000);
        step();
        rst_n = 1'b1;
        model_reset();
        #1;
        do_fetch(16'h1050, 0);

        // Reset while an instruction is presented
        rst_n = 1'b0;
        #1;
        $display("reset pulse during issue");
        check("issrst_valid", {15'b0, instr_valid}, 16'h0000);
        check("issrst_opcode", {12'b0, opcode}, 16'h0007);
        check("issrst_instr", instr, 16'h0000);
        step();
        rst_n = 1'b1;
        model_reset();
        #1;
        do_fetch(16'h3000, 1);
        do_issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
